// File: rtl/conv1d_pkg.sv
// ============================================================================
// conv1d_pkg : shared types and sizing helpers for the conv1d layer sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package conv1d_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_SIZE_K = 3;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_CNT_W  = 16;

  localparam int SPW       = DEF_STRIDE + 1;
  localparam int N_WORDS_W = DEF_SIZE_K + 1;
  localparam int WARMUP    = (DEF_SIZE_K + 2 * DEF_STRIDE) / (DEF_STRIDE + 1) - 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WEN   = 4'd1,
    S_WSEND = 4'd2,
    S_WWAIT = 4'd3,
    S_CEN   = 4'd4,
    S_CSEND = 4'd5,
    S_RWAIT = 4'd6,
    S_ROUT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  // Results lost while the engine shift register refills after a weight load
  function automatic int warmup_of(input int k, input int s);
    return (k + 2 * s) / (s + 1) - 1;
  endfunction

  // Width able to hold 0..n, never narrower than one bit
  function automatic int ctr_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int SEQ_CNT_W  = ctr_w((N_WORDS_W > SPW) ? N_WORDS_W : SPW);
  localparam int WARM_CNT_W = ctr_w(WARMUP);

endpackage

`default_nettype wire

// File: rtl/hs_reg1.sv
// ============================================================================
// hs_reg1 : single-entry stb/ack holding register between a source and a sink
// Rev 1.0
// ============================================================================
`default_nettype none

module hs_reg1 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  input  logic          i_stb,
  output logic          o_ack,
  output logic [DW-1:0] o_data,
  output logic          o_stb,
  input  logic          i_ack
);

  logic          r_full;
  logic [DW-1:0] r_data;

  // Accept only when empty, so fill and drain never coincide
  assign o_ack  = i_en && !r_full;
  assign o_stb  = r_full;
  assign o_data = r_data;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (r_full) begin
      if (i_ack) r_full <= 1'b0;
    end else if (i_stb && i_en) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv1d_seq_ctrl.sv
// ============================================================================
// conv1d_seq_ctrl : loads weights, drives the conv1d engine window by window,
// drops warm-up results and forwards the rest. CONV1D_SEQ_RELU_EN adds ReLU.
// Rev 1.0
// ============================================================================
`default_nettype none

module conv1d_seq_ctrl
  import conv1d_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int SIZE_K = DEF_SIZE_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n_out,
  output logic             o_busy,
  output logic             o_done,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_wstb,
  output logic             o_wack,
  input  logic [DW-1:0]    i_sdata,
  input  logic             i_sstb,
  output logic             o_sack,
  output logic             o_EN_w,
  output logic             o_EN_c,
  input  logic             i_eng_busy,
  output logic [DW-1:0]    o_edata,
  output logic             o_estb,
  input  logic             i_eack,
  input  logic [DW-1:0]    i_rdata,
  input  logic             i_rstb,
  output logic             o_rack,
  output logic [DW-1:0]    o_data,
  output logic             o_stb,
  input  logic             i_ack
);

  localparam int c_spw  = STRIDE + 1;
  localparam int c_nw   = SIZE_K + 1;
  localparam int c_warm = warmup_of(SIZE_K, STRIDE);
  localparam int c_cw   = ctr_w((c_nw > c_spw) ? c_nw : c_spw);
  localparam int c_ww   = ctr_w(c_warm);

  state_t           r_state;
  logic [c_cw-1:0]  r_cnt;
  logic [c_ww-1:0]  r_warm;
  logic [CNT_W-1:0] r_remain;
  logic             r_en_w;
  logic             r_en_c;
  logic             r_rack;
  logic             r_done;
  logic             r_busy;
  logic             r_stb;
  logic [DW-1:0]    r_data;

  logic             w_wphase;
  logic             w_sphase;
  logic [DW-1:0]    w_w_edata;
  logic [DW-1:0]    w_s_edata;
  logic             w_w_estb;
  logic             w_s_estb;
  logic             w_etx;
  logic [DW-1:0]    w_result;

  assign w_wphase = (r_state == S_WSEND);
  assign w_sphase = (r_state == S_CSEND);

  hs_reg1 #(.DW(DW)) u_wreg (
    .clk    (clk),
    .RSTn   (RSTn),
    .i_en   (w_wphase),
    .i_data (i_wdata),
    .i_stb  (i_wstb),
    .o_ack  (o_wack),
    .o_data (w_w_edata),
    .o_stb  (w_w_estb),
    .i_ack  (i_eack && w_wphase)
  );

  hs_reg1 #(.DW(DW)) u_sreg (
    .clk    (clk),
    .RSTn   (RSTn),
    .i_en   (w_sphase),
    .i_data (i_sdata),
    .i_stb  (i_sstb),
    .o_ack  (o_sack),
    .o_data (w_s_edata),
    .o_stb  (w_s_estb),
    .i_ack  (i_eack && w_sphase)
  );

  // Only the register of the current phase can be full
  assign o_estb  = w_w_estb | w_s_estb;
  assign o_edata = w_w_estb ? w_w_edata : w_s_edata;
  assign w_etx   = o_estb && i_eack;

`ifdef CONV1D_SEQ_RELU_EN
  assign w_result = i_rdata[DW-1] ? '0 : i_rdata;
`else
  assign w_result = i_rdata;
`endif

  assign o_EN_w = r_en_w;
  assign o_EN_c = r_en_c;
  assign o_rack = r_rack;
  assign o_done = r_done;
  assign o_busy = r_busy;
  assign o_stb  = r_stb;
  assign o_data = r_data;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_warm   <= '0;
      r_remain <= '0;
      r_en_w   <= 1'b0;
      r_en_c   <= 1'b0;
      r_rack   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_stb    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_en_w <= 1'b0;
      r_en_c <= 1'b0;
      r_rack <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_n_out == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy   <= 1'b1;
              r_remain <= i_n_out;
              r_warm   <= c_ww'(c_warm);
              r_state  <= S_WEN;
            end
          end
        end
        S_WEN: begin
          if (!i_eng_busy) begin
            r_en_w  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WSEND;
          end
        end
        S_WSEND: begin
          if (w_etx) begin
            if (r_cnt == c_cw'(c_nw - 1)) begin
              r_cnt   <= '0;
              r_state <= S_WWAIT;
            end else begin
              r_cnt <= r_cnt + c_cw'(1);
            end
          end
        end
        S_WWAIT: begin
          if (!i_eng_busy) r_state <= S_CEN;
        end
        S_CEN: begin
          // Hold off while the previous result is still being released
          if (!i_eng_busy && !r_rack) begin
            r_en_c  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_CSEND;
          end
        end
        S_CSEND: begin
          if (w_etx) begin
            if (r_cnt == c_cw'(c_spw - 1)) begin
              r_cnt   <= '0;
              r_state <= S_RWAIT;
            end else begin
              r_cnt <= r_cnt + c_cw'(1);
            end
          end
        end
        S_RWAIT: begin
          if (i_rstb) begin
            r_rack <= 1'b1;
            if (r_warm != '0) begin
              r_warm  <= r_warm - c_ww'(1);
              r_state <= S_CEN;
            end else begin
              r_data  <= w_result;
              r_stb   <= 1'b1;
              r_state <= S_ROUT;
            end
          end
        end
        S_ROUT: begin
          if (i_ack) begin
            r_stb    <= 1'b0;
            r_data   <= '0;
            r_remain <= r_remain - CNT_W'(1);
            r_state  <= (r_remain == CNT_W'(1)) ? S_DONE : S_CEN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv1d_seq_ctrl.sv
// ============================================================================
// tb_conv1d_seq_ctrl : directed bench with a behavioural conv1d engine model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv1d_seq_ctrl;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_n_out = '0;
  logic        o_busy, o_done;
  logic [31:0] i_wdata = '0;
  logic        i_wstb = 1'b0;
  logic        o_wack;
  logic [31:0] i_sdata = '0;
  logic        i_sstb = 1'b0;
  logic        o_sack;
  logic        o_EN_w, o_EN_c;
  logic        i_eng_busy;
  logic [31:0] o_edata;
  logic        o_estb;
  logic        i_eack;
  logic [31:0] i_rdata;
  logic        i_rstb;
  logic        o_rack;
  logic [31:0] o_data;
  logic        o_stb;
  logic        i_ack = 1'b0;

  always #5 clk = ~clk;

  conv1d_seq_ctrl dut (
    .clk(clk), .RSTn(RSTn), .i_start(i_start), .i_n_out(i_n_out),
    .o_busy(o_busy), .o_done(o_done),
    .i_wdata(i_wdata), .i_wstb(i_wstb), .o_wack(o_wack),
    .i_sdata(i_sdata), .i_sstb(i_sstb), .o_sack(o_sack),
    .o_EN_w(o_EN_w), .o_EN_c(o_EN_c), .i_eng_busy(i_eng_busy),
    .o_edata(o_edata), .o_estb(o_estb), .i_eack(i_eack),
    .i_rdata(i_rdata), .i_rstb(i_rstb), .o_rack(o_rack),
    .o_data(o_data), .o_stb(o_stb), .i_ack(i_ack)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: 3-tap MAC + bias over a shift register, max-pool of SPW outputs
  logic signed [31:0] ew [3];
  logic signed [31:0] eb, ex1, ex2, em;
  int est, ecnt;
  wire signed [31:0] e_y    = eb + ew[0] * ex1 + ew[1] * ex2 + ew[2] * $signed(o_edata);
  wire signed [31:0] e_pool = (ecnt == 0 || e_y > em) ? e_y : em;

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      est <= 0; ecnt <= 0; i_eng_busy <= 1'b0; i_eack <= 1'b0;
      i_rstb <= 1'b0; i_rdata <= '0; eb <= 0; ex1 <= 0; ex2 <= 0; em <= 0;
    end else begin
      case (est)
        0: if (o_EN_w) begin
             est <= 1; i_eng_busy <= 1'b1; i_eack <= 1'b1; ecnt <= 0; ex1 <= 0; ex2 <= 0;
           end else if (o_EN_c) begin
             est <= 2; i_eng_busy <= 1'b1; i_eack <= 1'b1; ecnt <= 0;
           end
        1: if (o_estb && i_eack) begin
             i_eack <= 1'b0;
             if (ecnt < 3) ew[ecnt] <= o_edata; else eb <= o_edata;
             if (ecnt == 3) begin est <= 0; i_eng_busy <= 1'b0; end
             else ecnt <= ecnt + 1;
           end else i_eack <= 1'b1;
        2: if (o_estb && i_eack) begin
             i_eack <= 1'b0; ex1 <= ex2; ex2 <= $signed(o_edata); em <= e_pool;
             if (ecnt == 1) begin est <= 3; i_rstb <= 1'b1; i_rdata <= e_pool; end
             else ecnt <= ecnt + 1;
           end else i_eack <= 1'b1;
        default: if (o_rack) begin i_rstb <= 1'b0; i_eng_busy <= 1'b0; est <= 0; end
      endcase
    end
  end

  int enw_cnt = 0, enc_cnt = 0, done_cnt = 0, otx_cnt = 0, wtx_cnt = 0, stx_cnt = 0;
  logic prev_enw = 1'b0, prev_enc = 1'b0;

  always @(negedge clk) begin
    if (o_EN_w) begin
      check("en_w_while_busy", 32'(i_eng_busy), 32'd0);
      check("en_w_back_to_back", 32'(prev_enw), 32'd0);
      enw_cnt <= enw_cnt + 1;
    end
    if (o_EN_c) begin
      check("en_c_while_busy", 32'(i_eng_busy), 32'd0);
      check("en_c_back_to_back", 32'(prev_enc), 32'd0);
      enc_cnt <= enc_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_stb && i_ack) otx_cnt <= otx_cnt + 1;
    if (o_wack && i_wstb) wtx_cnt <= wtx_cnt + 1;
    if (o_sack && i_sstb) stx_cnt <= stx_cnt + 1;
    prev_enw <= o_EN_w;
    prev_enc <= o_EN_c;
  end

  logic [31:0] wbuf [4];
  logic [31:0] sbuf [8];
  logic [31:0] ebuf [4];

  task automatic send_stream(input bit smp, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int g = gap ? int'($urandom_range(0, 3)) : 0;
      int t = 0;
      bit ok = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      if (smp) begin i_sdata = sbuf[i]; i_sstb = 1'b1; end
      else     begin i_wdata = wbuf[i]; i_wstb = 1'b1; end
      while (!ok && t < 600) begin
        @(negedge clk);
        ok = smp ? o_sack : o_wack;
        @(posedge clk); #1;
        t++;
      end
      if (smp) i_sstb = 1'b0; else i_wstb = 1'b0;
      check(smp ? "sample_accepted" : "weight_accepted", 32'(ok), 32'd1);
    end
  endtask

  task automatic sink(input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      bit stable = 1'b1;
      logic [31:0] d0;
      @(negedge clk);
      while (!o_stb && t < 600) begin @(negedge clk); t++; end
      check($sformatf("out%0d_present", k), 32'(o_stb), 32'd1);
      d0 = o_data;
      repeat (hold) begin
        @(negedge clk);
        if (!o_stb || o_data !== d0) stable = 1'b0;
      end
      if (hold > 0) check($sformatf("out%0d_stable", k), 32'(stable), 32'd1);
      @(posedge clk); #1 i_ack = 1'b1;
      @(negedge clk);
      check($sformatf("out%0d_data", k), o_data, ebuf[k]);
      @(posedge clk); #1 i_ack = 1'b0;
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    @(posedge clk); #1 i_start = 1'b1; i_n_out = n;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic run(input int nsmp, input int n, input bit gap, input int hold);
    int d0 = done_cnt;
    int t = 0;
    pulse_start(16'(n));
    fork
      send_stream(1'b0, 4, gap);
      send_stream(1'b1, nsmp, gap);
      sink(n, hold);
      if (gap) begin
        repeat (12) @(posedge clk);
        #1 i_start = 1'b1; i_n_out = 16'd7;
        @(posedge clk); #1 i_start = 1'b0;
      end
    join
    while (done_cnt == d0 && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
  endtask

  task automatic load_basic(input logic [31:0] w, input logic [31:0] b);
    for (int i = 0; i < 3; i++) wbuf[i] = w;
    wbuf[3] = b;
    for (int i = 0; i < 8; i++) sbuf[i] = 32'(i + 1);
  endtask

  int b_enw, b_enc, b_done, b_otx, b_wtx, b_stx;

  task automatic snap();
    b_enw = enw_cnt; b_enc = enc_cnt; b_done = done_cnt;
    b_otx = otx_cnt; b_wtx = wtx_cnt; b_stx = stx_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_wack", 32'(o_wack), 0);
    check("rst_sack", 32'(o_sack), 0);
    check("rst_en_w", 32'(o_EN_w), 0);
    check("rst_en_c", 32'(o_EN_c), 0);
    check("rst_estb", 32'(o_estb), 0);
    check("rst_rack", 32'(o_rack), 0);
    check("rst_stb", 32'(o_stb), 0);
    check("rst_data", o_data, 0);
    RSTn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Unit weights, no bias: windows pool to 3 (dropped), 9, 15
    load_basic(32'd1, 32'd0);
    ebuf[0] = 32'd9; ebuf[1] = 32'd15;
    snap();
    run(6, 2, 1'b0, 0);
    check("a_done_pulses", 32'(done_cnt - b_done), 1);
    check("a_en_w_pulses", 32'(enw_cnt - b_enw), 1);
    check("a_en_c_pulses", 32'(enc_cnt - b_enc), 3);
    check("a_out_xfers", 32'(otx_cnt - b_otx), 2);
    check("a_busy_after", 32'(o_busy), 0);

    // Bias 10 with stream gaps, a held-off sink and a stray i_start mid-run
    load_basic(32'd1, 32'd10);
    ebuf[0] = 32'd19; ebuf[1] = 32'd25;
    snap();
    run(6, 2, 1'b1, 20);
    check("b_done_pulses", 32'(done_cnt - b_done), 1);
    check("b_en_w_pulses", 32'(enw_cnt - b_enw), 1);
    check("b_en_c_pulses", 32'(enc_cnt - b_enc), 3);
    check("b_out_xfers", 32'(otx_cnt - b_otx), 2);
    check("b_busy_after", 32'(o_busy), 0);

    // Zero results requested
    snap();
    pulse_start(16'd0);
    @(negedge clk);
    check("z_done_next", 32'(o_done), 1);
    check("z_busy", 32'(o_busy), 0);
    repeat (8) @(posedge clk);
    #1;
    check("z_done_pulses", 32'(done_cnt - b_done), 1);
    check("z_en_w_pulses", 32'(enw_cnt - b_enw), 0);
    check("z_w_xfers", 32'(wtx_cnt - b_wtx), 0);
    check("z_s_xfers", 32'(stx_cnt - b_stx), 0);

    // Reset while the sample window is half sent
    load_basic(32'd1, 32'd0);
    pulse_start(16'd2);
    send_stream(1'b0, 4, 1'b0);
    send_stream(1'b1, 1, 1'b0);
    @(posedge clk); #1;
    RSTn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_estb", 32'(o_estb), 0);
    check("mid_rst_sack", 32'(o_sack), 0);
    check("mid_rst_en_c", 32'(o_EN_c), 0);
    check("mid_rst_stb", 32'(o_stb), 0);
    check("mid_rst_done", 32'(o_done), 0);
    snap();
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt - b_done), 0);
    check("mid_rst_busy_low", 32'(o_busy), 0);

    ebuf[0] = 32'd9; ebuf[1] = 32'd15;
    snap();
    run(6, 2, 1'b0, 0);
    check("c_done_pulses", 32'(done_cnt - b_done), 1);
    check("c_en_c_pulses", 32'(enc_cnt - b_enc), 3);

    // Negative taps: kept window pools to -6
    load_basic(32'hFFFF_FFFF, 32'd0);
`ifdef CONV1D_SEQ_RELU_EN
    ebuf[0] = 32'd0;
`else
    ebuf[0] = 32'hFFFF_FFFA;
`endif
    snap();
    run(4, 1, 1'b0, 0);
    check("r_done_pulses", 32'(done_cnt - b_done), 1);
    check("r_en_c_pulses", 32'(enc_cnt - b_enc), 2);
    check("r_out_xfers", 32'(otx_cnt - b_otx), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire
